// File: rtl/cv32e_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cv32e_data_mem_responder
// Purpose  : Single-outstanding data-memory responder for a req/gnt/rvalid
//            initiator. Grants combinationally in IDLE and RESP, inserts
//            WAIT_STATES idle cycles before the response, and answers every
//            accepted transfer with exactly one rvalid pulse. Writes commit
//            at the end of the RESP cycle. A read accepted in a write's RESP
//            cycle to the same word sees the merged write data.
// Ports    : clk_i, rst_i (async, active high)
//            data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i
//            data_gnt_o, data_rvalid_o, data_rdata_o
// Revision : 1.0 - initial release
// ============================================================================
module cv32e_data_mem_responder #(
  parameter int CORE_ADDR_WIDTH = 32,
  parameter int CORE_DATA_WIDTH = 32,
  parameter int CORE_BE_WIDTH   = 4,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int WAIT_STATES     = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       data_req_i,
  input  logic [CORE_ADDR_WIDTH-1:0] data_addr_i,
  input  logic                       data_we_i,
  input  logic [CORE_BE_WIDTH-1:0]   data_be_i,
  input  logic [CORE_DATA_WIDTH-1:0] data_wdata_i,
  output logic                       data_gnt_o,
  output logic                       data_rvalid_o,
  output logic [CORE_DATA_WIDTH-1:0] data_rdata_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       we_q, we_d;
  logic [CORE_BE_WIDTH-1:0]   be_q, be_d;
  logic [CORE_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CORE_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [CORE_DATA_WIDTH-1:0] mem_q [MEM_DEPTH_WORDS];

  logic [IDX_W-1:0]           req_idx;
  logic                       accept;
  logic [CORE_DATA_WIDTH-1:0] merged_word;
  logic [CORE_DATA_WIDTH-1:0] new_rd_word;

  // Only the word-index bits are decoded; the rest alias.
  logic unused_addr;
  assign unused_addr = ^data_addr_i;

  assign req_idx = data_addr_i[IDX_W+1:2];

  // The reset gate keeps gnt low while rst_i is held, even with req high.
  assign accept = data_req_i & (state_q != S_WAIT) & ~rst_i;

  assign data_gnt_o    = accept;
  assign data_rvalid_o = (state_q == S_RESP);
  assign data_rdata_o  = rdata_q;

  // Word as it will look once the write in RESP has committed.
  always_comb begin
    merged_word = mem_q[idx_q];
    for (int b = 0; b < CORE_BE_WIDTH; b++) begin
      if (be_q[b]) merged_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Zero-wait reads accepted in a write's RESP cycle bypass the array,
  // since the commit happens on the same edge as the read sample.
  assign new_rd_word = (state_q == S_RESP && we_q && idx_q == req_idx) ?
                       merged_word : mem_q[req_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          idx_d   = req_idx;
          we_d    = data_we_i;
          be_d    = data_be_i;
          wdata_d = data_wdata_i;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            rdata_d = data_we_i ? '0 : new_rd_word;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end
        end else if (state_q == S_RESP) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_RESP;
          // Any earlier write has already committed by now.
          rdata_d = we_q ? '0 : mem_q[idx_q];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is intentionally not reset; an aborted write never reaches here
  // because reset forces the FSM out of RESP.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == S_RESP && we_q) begin
      for (int b = 0; b < CORE_BE_WIDTH; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cv32e_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e_data_mem_responder
// Purpose  : Scoreboard bench for cv32e_data_mem_responder. Three instances
//            with WAIT_STATES 0, 2 and 3 are driven one at a time; expected
//            responses (instance, data, cycle) are queued at grant and
//            matched against rvalid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e_data_mem_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req    [N];
  logic [31:0] addr   [N];
  logic        we     [N];
  logic [3:0]  be     [N];
  logic [31:0] wdata  [N];
  logic        gnt    [N];
  logic        rvalid [N];
  logic [31:0] rdata  [N];

  always #5 clk = ~clk;

  function automatic int ws_of(input int inst);
    return (inst == 0) ? 0 : (inst == 1) ? 2 : 3;
  endfunction

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      cv32e_data_mem_responder #(
        .CORE_ADDR_WIDTH(32),
        .CORE_DATA_WIDTH(32),
        .CORE_BE_WIDTH  (4),
        .MEM_DEPTH_WORDS(1024),
        .WAIT_STATES    ((g == 0) ? 0 : (g == 1) ? 2 : 3)
      ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_req_i   (req[g]),
        .data_addr_i  (addr[g]),
        .data_we_i    (we[g]),
        .data_be_i    (be[g]),
        .data_wdata_i (wdata[g]),
        .data_gnt_o   (gnt[g]),
        .data_rvalid_o(rvalid[g]),
        .data_rdata_o (rdata[g])
      );
    end
  endgenerate

  typedef struct {
    int          inst;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  sb_t sb_q [$];
  sb_t mon_e;
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge. Holds req until granted, queues the
  // expected response, and returns #1 after the accept edge with req low.
  task automatic txn(input int inst, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d,
                     input logic [31:0] exp_rd, output int waits);
    req[inst] = 1'b1; we[inst] = w; addr[inst] = a; be[inst] = b; wdata[inst] = d;
    waits = 0;
    @(negedge clk);
    while (!gnt[inst] && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!gnt[inst]) begin
      check_eq("gnt_timeout", 32'd0, 32'd1);
      req[inst] = 1'b0;
      return;
    end
    sb_q.push_back('{inst, (w ? 32'd0 : exp_rd), cyc + 1 + ws_of(inst)});
    @(posedge clk);
    #1;
    req[inst] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (rvalid[i]) begin
          if (sb_q.size() == 0) begin
            check_eq("spurious_rvalid", 32'(i), 32'hFFFF_FFFF);
          end else begin
            mon_e = sb_q.pop_front();
            check_eq("rvalid_inst", 32'(i), 32'(mon_e.inst));
            check_eq("rdata", rdata[i], mon_e.data);
            check_eq("rvalid_cycle", 32'(cyc), 32'(mon_e.cyc));
          end
        end
      end
    end
  end

  int w;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b1; addr[i] = 32'h0; we[i] = 1'b0; be[i] = 4'hF; wdata[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_eq("rst_gnt", 32'(gnt[i]), 32'd0);
      check_eq("rst_rvalid", 32'(rvalid[i]), 32'd0);
      check_eq("rst_rdata", rdata[i], 32'd0);
    end
    for (int i = 0; i < N; i++) req[i] = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero wait states: write, read back, partial write, forwarding, alias.
    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, w);
    check_eq("first_gnt_wait", 32'(w), 32'd0);
    txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, w);
    check_eq("rd_gnt_wait", 32'(w), 32'd0);
    txn(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, w);
    txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, w);
    txn(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, w);
    txn(0, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 32'h0, w);
    txn(0, 1'b0, 32'h30, 4'hF, 32'h0, 32'hCAFEF00D, w);
    check_eq("fwd_gnt_wait", 32'(w), 32'd0);
    txn(0, 1'b1, 32'h24, 4'hF, 32'h01020304, 32'h0, w);
    txn(0, 1'b1, 32'h24, 4'b0000, 32'hFFFFFFFF, 32'h0, w);
    txn(0, 1'b0, 32'h24, 4'hF, 32'h0, 32'h01020304, w);
    txn(0, 1'b1, 32'h1004, 4'hF, 32'h0BADF00D, 32'h0, w);
    txn(0, 1'b0, 32'h0004, 4'hF, 32'h0, 32'h0BADF00D, w);
    txn(0, 1'b0, 32'h1007, 4'hF, 32'h0, 32'h0BADF00D, w);
    repeat (3) @(posedge clk);
    #1;

    // Three wait states with req held across transfers.
    txn(2, 1'b1, 32'h50, 4'hF, 32'h00000001, 32'h0, w);
    check_eq("ws3_first_wait", 32'(w), 32'd0);
    txn(2, 1'b1, 32'h54, 4'hF, 32'h00000002, 32'h0, w);
    check_eq("ws3_gap", 32'(w), 32'd3);
    txn(2, 1'b0, 32'h50, 4'hF, 32'h0, 32'h00000001, w);
    check_eq("ws3_gap", 32'(w), 32'd3);
    txn(2, 1'b0, 32'h54, 4'hF, 32'h0, 32'h00000002, w);
    check_eq("ws3_gap", 32'(w), 32'd3);
    repeat (6) @(posedge clk);
    #1;

    // Reset abort in WAIT on the two-wait-state instance.
    txn(1, 1'b1, 32'h40, 4'hF, 32'h55AA55AA, 32'h0, w);
    txn(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h55AA55AA, w);
    repeat (5) @(posedge clk);
    #1;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h40; be[1] = 4'hF; wdata[1] = 32'h12345678;
    @(negedge clk);
    check_eq("abort_gnt", 32'(gnt[1]), 32'd1);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    @(negedge clk);
    check_eq("wait_gnt", 32'(gnt[1]), 32'd0);
    check_eq("wait_rvalid", 32'(rvalid[1]), 32'd0);
    #1;
    rst = 1'b1;
    req[1] = 1'b1;
    #1;
    check_eq("abort_gnt_rst", 32'(gnt[1]), 32'd0);
    check_eq("abort_rvalid_rst", 32'(rvalid[1]), 32'd0);
    check_eq("abort_rdata_rst", rdata[1], 32'd0);
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    txn(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h55AA55AA, w);
    check_eq("post_rst_wait", 32'(w), 32'd0);

    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cv32e_data_mem_responder.md
CV32E_DATA_MEM_RESPONDER -- requirements
Module: cv32e_data_mem_responder

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly as follows:
- CORE_ADDR_WIDTH, 32, address width.
- CORE_DATA_WIDTH, 32, data width.
- CORE_BE_WIDTH, 4, byte-enable width.
- MEM_DEPTH_WORDS, 1024, word count; power of two, at least 2.
- WAIT_STATES, 0, extra cycles between grant and response; range 0..7.

REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.

REQ-003 Ports (name, direction, width, meaning) SHALL be exactly as follows:
- clk_i, in, 1, clock.
- rst_i, in, 1, async active-high reset.
- data_req_i, in, 1, initiator request.
- data_addr_i, in, CORE_ADDR_WIDTH, byte address.
- data_we_i, in, 1, 1 = write.
- data_be_i, in, CORE_BE_WIDTH, byte enables.
- data_wdata_i, in, CORE_DATA_WIDTH, write data.
- data_gnt_o, out, 1, request accepted this cycle.
- data_rvalid_o, out, 1, response valid.
- data_rdata_o, out, CORE_DATA_WIDTH, read data.

Function
REQ-004 Protocol: the initiator holds req and its attributes stable until gnt. A transfer is accepted on the clock edge where req=1 and gnt=1.

REQ-005 At most one transaction SHALL be outstanding. Every accepted transaction SHALL produce exactly one rvalid pulse, in acceptance order.

REQ-006 The FSM SHALL have three states: IDLE, WAIT and RESP.

REQ-007 IDLE: gnt = req (combinational).
- On acceptance, latch word index, we, be and wdata.
- Go to RESP if WAIT_STATES=0; otherwise go to WAIT and load the counter with WAIT_STATES.

REQ-008 WAIT: gnt=0 and rvalid=0.
- The counter decrements each cycle.
- The FSM goes to RESP on the cycle the counter equals 1.
- Total latency from the accept edge to rvalid high is WAIT_STATES+1 cycles.

REQ-009 RESP: rvalid=1 for exactly one cycle. gnt = req, so back-to-back acceptance is allowed.
- On acceptance: go to WAIT or RESP per REQ-007.
- Otherwise: go to IDLE.

REQ-010 Sustained throughput with WAIT_STATES=0 SHALL be one transaction per cycle.

REQ-011 Address mapping:
- Word index = data_addr_i[log2(MEM_DEPTH_WORDS)+1:2].
- Bits [1:0] are ignored.
- Upper bits are ignored, so addresses alias modulo MEM_DEPTH_WORDS*4.

REQ-012 Writes SHALL commit on the clock edge ending the RESP cycle.
- Only bytes with be=1 are updated.
- be=0 leaves memory unchanged but still produces a response.

REQ-013 Read response: data_rdata_o SHALL be registered and loaded on the edge entering RESP. For writes it SHALL be 0.

REQ-014 Read-after-write forwarding: a read to the same word index accepted in the RESP cycle of a write SHALL return the post-write merged word.

REQ-015 Memory contents SHALL NOT be reset or initialised.

REQ-016 gnt SHALL be 0 in WAIT, and 0 whenever req=0.

Reset
REQ-017 While rst_i=1 the block SHALL hold:
- FSM = IDLE, counter = 0.
- data_gnt_o = 0, data_rvalid_o = 0, data_rdata_o = 0.
- Latched attributes = 0.

REQ-018 Reset asserted in WAIT or RESP SHALL abort the transaction.
- A pending write is discarded (no memory update).
- No rvalid is produced after reset release.

REQ-019 After rst_i deasserts, the first acceptance SHALL be possible on the first rising edge with req=1.

Verification
REQ-020 Write then read, WAIT_STATES=0:
- Stimulus: write addr 0x10, be=4'hF, wdata 0xDEADBEEF; then read 0x10.
- Response: gnt same cycle as each req; rvalid 1 cycle after each accept; read rdata = 0xDEADBEEF; write rdata = 0.

REQ-021 Partial byte write:
- Stimulus: word 0x20 preloaded with 0x11223344; write be=4'b0101, wdata 0xAABBCCDD; then read 0x20.
- Response: rdata = 0x11BB33DD.

REQ-022 Back-to-back forwarding, WAIT_STATES=0:
- Stimulus: write 0x30 = 0xCAFEF00D, immediately followed by a read of 0x30 (req held).
- Response: read granted in the write's RESP cycle; rvalid high on 2 consecutive cycles; read rdata = 0xCAFEF00D.

REQ-023 Wait states, WAIT_STATES=3, req held continuously with reads:
- Response: rvalid 4 cycles after each accept; gnt low for 3 cycles between grants; one rvalid per grant.

REQ-024 Aliasing and reset abort, MEM_DEPTH_WORDS=1024:
- Stimulus: write 0x1004, then read 0x0004.
- Response: read returns the written data.
- Stimulus: start a write with WAIT_STATES=2; assert rst_i in WAIT.
- Response: all outputs 0 immediately; no rvalid after release; that word keeps its prior value.
